// File: rtl/ram_model.sv
// Parametrised pipelined word memory with byte enables, fault reporting and a sticky halt flag.
// Optional bounds checking is compiled in with `define RAM_BOUNDS_CHECK_EN.
module ram_model #(
  parameter int              DW        = 64,
  parameter int              DEPTH     = 1024,
  parameter int              AW        = 64,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter logic [AW-1:0]   END_ADDR  = BASE_ADDR + AW'(DEPTH * (DW / 8)) - AW'(DW / 8),
  parameter int              LATENCY   = 1,
  parameter string           INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     write,
  input  logic [DW/8-1:0]   be,
  output logic [DW-1:0]     read,
  output logic              ack,
  output logic              rw_ack,
  output logic              exception,
  output logic              halt
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(NB - 1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] off_addr;
  logic          misaligned;
  logic          fault;
  logic [IW-1:0] idx;

  assign off_addr   = addr - BASE_ADDR;
  assign misaligned = |(addr & ALIGN_MASK);

`ifdef RAM_BOUNDS_CHECK_EN
  logic [AW-1:0] word_idx;
  assign word_idx = off_addr >> OFF;
  assign idx      = IW'(word_idx);
  assign fault    = misaligned | (addr < BASE_ADDR) | (word_idx >= AW'(DEPTH));
`else
  // Index wraps modulo DEPTH by truncation, so only misalignment can fault.
  assign idx   = IW'(off_addr >> OFF);
  assign fault = misaligned;
`endif

  // Memory contents survive reset; only accepted, non-faulting writes commit.
  always_ff @(posedge clk) begin
    if (!rst && req && rw && !fault) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= write[8*i +: 8];
        end
      end
    end
  end

  logic [LATENCY:0] pv;
  logic [LATENCY:0] prw;
  logic [LATENCY:0] pf;
  logic [DW-1:0]    pd [LATENCY+1];

  // Stage 0 captures the request at the accept edge; the last stage drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv  <= '0;
      prw <= '0;
      pf  <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        pd[s] <= '0;
      end
    end else begin
      pv[0]  <= req;
      prw[0] <= req & rw;
      pf[0]  <= req & fault;
      pd[0]  <= (req && !rw && !fault) ? mem[idx] : '0;
      for (int s = 1; s <= LATENCY; s++) begin
        pv[s]  <= pv[s-1];
        prw[s] <= prw[s-1];
        pf[s]  <= pf[s-1];
        pd[s]  <= pd[s-1];
      end
    end
  end

  assign ack       = pv[LATENCY];
  assign rw_ack    = prw[LATENCY];
  assign exception = pf[LATENCY];
  assign read      = pd[LATENCY];

  // Halt latches on any accepted access to END_ADDR and clears only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (req && (addr == END_ADDR)) begin
      halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_model.sv
// Self-checking bench for ram_model: three instances (LATENCY 1, 3, 4) share stimulus and are
// compared every cycle against a word-array reference model plus directed scenario checks.
module tb_ram_model;

  localparam int          DEPTH = 64;
  localparam logic [63:0] END_A = 64'd504;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rw;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;

  logic [63:0] rd  [3];
  logic        ack [3];
  logic        rwa [3];
  logic        exc [3];
  logic        hlt [3];

  int lat [3] = '{1, 3, 4};

  always #5 clk = ~clk;

  ram_model #(.DW(64), .DEPTH(DEPTH), .AW(64), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .write(wdata), .be(be),
    .read(rd[0]), .ack(ack[0]), .rw_ack(rwa[0]), .exception(exc[0]), .halt(hlt[0]));
  ram_model #(.DW(64), .DEPTH(DEPTH), .AW(64), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .write(wdata), .be(be),
    .read(rd[1]), .ack(ack[1]), .rw_ack(rwa[1]), .exception(exc[1]), .halt(hlt[1]));
  ram_model #(.DW(64), .DEPTH(DEPTH), .AW(64), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .write(wdata), .be(be),
    .read(rd[2]), .ack(ack[2]), .rw_ack(rwa[2]), .exception(exc[2]), .halt(hlt[2]));

  int checks;
  int fails;

  // Reference model: word array, halt flag, and per-edge record of expected responses.
  logic [63:0] mdl [DEPTH];
  bit          hm;
  int          n;
  bit          ev   [8192];
  bit          erw  [8192];
  bit          eexc [8192];
  logic [63:0] ed   [8192];

  function automatic bit is_fault(input logic [63:0] a);
    bit f;
    f = (a % 64'd8) != 64'd0;
`ifdef RAM_BOUNDS_CHECK_EN
    f = f || ((a / 64'd8) >= 64'd64);
`endif
    return f;
  endfunction

  int  mj;
  int  mw;
  bit  mf;
  bit  mexp;

  // Scoreboard: update the model at each edge, then compare every instance 1 time unit later.
  always @(posedge clk) begin
    n = n + 1;
    if (rst) begin
      for (int k = n - 5; k <= n; k++) begin
        if (k >= 0) ev[k] = 1'b0;
      end
      hm = 1'b0;
    end else begin
      ev[n] = req;
      if (req) begin
        mf      = is_fault(addr);
        mw      = int'((addr / 64'd8) % 64'd64);
        erw[n]  = rw;
        eexc[n] = mf;
        ed[n]   = (!rw && !mf) ? mdl[mw] : 64'd0;
        if (rw && !mf) begin
          for (int b = 0; b < 8; b++) begin
            if (be[b]) mdl[mw][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        if (addr == END_A) hm = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      mj   = n - lat[i];
      mexp = (mj >= 0) ? ev[mj] : 1'b0;
      checks++;
      if (ack[i] !== mexp) begin
        fails++;
        $display("FAIL ack_L%0d edge %0d: got %b expected %b", lat[i], n, ack[i], mexp);
      end
      if (mexp) begin
        checks++;
        if (rwa[i] !== erw[mj] || exc[i] !== eexc[mj]) begin
          fails++;
          $display("FAIL rw_exc_L%0d edge %0d: got rw=%b exc=%b expected rw=%b exc=%b",
                   lat[i], n, rwa[i], exc[i], erw[mj], eexc[mj]);
        end
        if (!erw[mj]) begin
          checks++;
          if (rd[i] !== ed[mj]) begin
            fails++;
            $display("FAIL read_L%0d edge %0d: got %h expected %h", lat[i], n, rd[i], ed[mj]);
          end
        end
      end
      checks++;
      if (hlt[i] !== hm) begin
        fails++;
        $display("FAIL halt_L%0d edge %0d: got %b expected %b", lat[i], n, hlt[i], hm);
      end
    end
  end

  task automatic drive(input bit r, input bit w, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] b);
    req   = r;
    rw    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], ack[i], rwa[i], exc[i], hlt[i]} !== 68'd0) begin
        fails++;
        $display("FAIL reset_state_L%0d: got rd=%h ack=%b rw=%b exc=%b halt=%b expected all 0",
                 lat[i], rd[i], ack[i], rwa[i], exc[i], hlt[i]);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_init;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF);
    end
    repeat (5) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  task automatic test_reset_midburst;
    drive(1'b1, 1'b1, 64'h20, 64'h0123_4567_89AB_CDEF, 8'hFF);
    drive(1'b1, 1'b1, 64'h28, 64'hFEDC_BA98_7654_3210, 8'hFF);
    req = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], ack[i], rwa[i], exc[i], hlt[i]} !== 68'd0) begin
        fails++;
        $display("FAIL midburst_reset_L%0d: got rd=%h ack=%b rw=%b exc=%b halt=%b expected all 0",
                 lat[i], rd[i], ack[i], rwa[i], exc[i], hlt[i]);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ack[1] !== 1'b0) begin
        fails++;
        $display("FAIL dropped_ack_L3 cycle %0d: got %b expected 0", c, ack[1]);
      end
    end
    #1;
  endtask

  task automatic test_write_read;
    drive(1'b1, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 8'h00);
    checks++;
    if (ack[0] !== 1'b1 || rwa[0] !== 1'b1) begin
      fails++;
      $display("FAIL wr_ack_L1: got ack=%b rw=%b expected ack=1 rw=1", ack[0], rwa[0]);
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    checks++;
    if (ack[0] !== 1'b1 || rwa[0] !== 1'b0 || exc[0] !== 1'b0 || rd[0] !== 64'h1122_3344_5566_7788) begin
      fails++;
      $display("FAIL raw_L1: got ack=%b rw=%b exc=%b rd=%h expected 1 0 0 1122334455667788",
               ack[0], rwa[0], exc[0], rd[0]);
    end
    repeat (4) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  task automatic test_byte_lanes;
    drive(1'b1, 1'b1, 64'h0, 64'h0, 8'hFF);
    drive(1'b1, 1'b1, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    drive(1'b1, 1'b0, 64'h0, 64'd0, 8'h00);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    checks++;
    if (ack[0] !== 1'b1 || rwa[0] !== 1'b0 || rd[0] !== 64'h0000_0000_AAAA_AAAA) begin
      fails++;
      $display("FAIL byte_lanes: got ack=%b rw=%b rd=%h expected 1 0 00000000aaaaaaaa",
               ack[0], rwa[0], rd[0]);
    end
    repeat (4) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  task automatic test_burst;
    int          start;
    int          when [$];
    logic [63:0] got  [$];
    start = n + 1;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 64'(i * 8), 64'd0, 8'h00);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
      end
      begin
        repeat (14) begin
          @(posedge clk);
          #1;
          if (ack[2]) begin
            when.push_back(n);
            got.push_back(rd[2]);
          end
        end
      end
    join
    checks++;
    if (when.size() != 8) begin
      fails++;
      $display("FAIL burst_count: got %0d acks expected 8", when.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (when[i] != start + 4 + i || got[i] !== mdl[i]) begin
          fails++;
          $display("FAIL burst_%0d: got edge %0d data %h expected edge %0d data %h",
                   i, when[i], got[i], start + 4 + i, mdl[i]);
        end
      end
    end
    #1;
  endtask

  task automatic test_faults;
    logic [63:0] exp0;
    bit          exp_exc;
    drive(1'b1, 1'b0, 64'h3, 64'd0, 8'h00);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    checks++;
    if (ack[0] !== 1'b1 || exc[0] !== 1'b1 || rd[0] !== 64'd0) begin
      fails++;
      $display("FAIL misaligned_read: got ack=%b exc=%b rd=%h expected 1 1 0", ack[0], exc[0], rd[0]);
    end
    drive(1'b1, 1'b1, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    drive(1'b1, 1'b1, 64'(DEPTH * 8), 64'h5555_6666_7777_8888, 8'hFF);
    drive(1'b1, 1'b0, 64'h0, 64'd0, 8'h00);
`ifdef RAM_BOUNDS_CHECK_EN
    exp_exc = 1'b1;
    exp0    = 64'hCAFE_F00D_DEAD_BEEF;
`else
    exp_exc = 1'b0;
    exp0    = 64'h5555_6666_7777_8888;
`endif
    checks++;
    if (ack[0] !== 1'b1 || rwa[0] !== 1'b1 || exc[0] !== exp_exc) begin
      fails++;
      $display("FAIL oob_write_exc: got ack=%b rw=%b exc=%b expected 1 1 %b", ack[0], rwa[0], exc[0], exp_exc);
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    checks++;
    if (ack[0] !== 1'b1 || rd[0] !== exp0) begin
      fails++;
      $display("FAIL oob_write_word0: got ack=%b rd=%h expected 1 %h", ack[0], rd[0], exp0);
    end
    repeat (4) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  task automatic test_random;
    logic [63:0] a;
    int          k;
    for (int c = 0; c < 400; c++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 6)      a = 64'($urandom_range(0, DEPTH - 2) * 8);
      else if (k == 7) a = 64'($urandom_range(0, DEPTH - 2) * 8 + $urandom_range(1, 7));
      else             a = 64'($urandom_range(DEPTH, 2 * DEPTH - 1) * 8);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
    repeat (5) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  task automatic test_halt;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hlt[i] !== 1'b0) begin
        fails++;
        $display("FAIL halt_pre_L%0d: got %b expected 0", lat[i], hlt[i]);
      end
    end
    drive(1'b1, 1'b0, END_A, 64'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hlt[i] !== 1'b1) begin
        fails++;
        $display("FAIL halt_set_L%0d: got %b expected 1", lat[i], hlt[i]);
      end
    end
    for (int c = 0; c < 6; c++) drive(1'b1, c[0], 64'(c * 8), 64'(c), 8'hFF);
    repeat (5) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hlt[i] !== 1'b1) begin
        fails++;
        $display("FAIL halt_sticky_L%0d: got %b expected 1", lat[i], hlt[i]);
      end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hlt[i] !== 1'b0) begin
        fails++;
        $display("FAIL halt_clear_L%0d: got %b expected 0", lat[i], hlt[i]);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    n      = -1;
    hm     = 1'b0;
    rst    = 1'b1;
    req    = 1'b0;
    rw     = 1'b0;
    addr   = 64'd0;
    wdata  = 64'd0;
    be     = 8'h00;
    test_reset;
    test_init;
    test_reset_midburst;
    test_write_read;
    test_byte_lanes;
    test_burst;
    test_faults;
    test_random;
    test_halt;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
